// File: rtl/stream_fir_ntap.sv
// -----------------------------------------------------------------------------
// stream_fir_ntap
//
// Streaming N-tap FIR kernel with an input FIFO, bypass mode, synchronous
// flush, fixed-point output scaling with saturation and an output sample
// counter.
//
// The datapath has three parts:
//   - a first-word-fall-through FIFO on the input stream;
//   - a single output register (out_data/out_valid) that pops the FIFO head;
//   - a delay line of the last NTAPS-1 accepted samples.
// On each accept the output register is loaded with either the FIR result or
// the raw head sample.
//
// Ports:
//   clock            sole clock, rising edge
//   reset            asynchronous, active-low reset
//   inStream0_data   input sample (signed, DATA_W)
//   inStream0_wr     input write strobe
//   inStream0_full   FIFO full; writes while high are dropped
//   outStream0_data  result sample (signed, DATA_W)
//   outStream0_wr    result strobe, one sample per strobe
//   outStream0_full  downstream full; no strobe while high
//   coeff            packed coefficients, c_k = coeff[k*COEFF_W +: COEFF_W]
//   cfg_mode         0 = FIR, 1 = bypass (sampled on accept)
//   flush            synchronous clear of FIFO, delay line, output register
//   sample_count     number of outStream0_wr strobes since reset/flush
// -----------------------------------------------------------------------------
module stream_fir_ntap #(
  parameter int DATA_W     = 32,
  parameter int COEFF_W    = 32,
  parameter int NTAPS      = 4,
  parameter int FIFO_DEPTH = 64,
  parameter int SHIFT      = 0
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [DATA_W-1:0]          inStream0_data,
  input  logic                       inStream0_wr,
  output logic                       inStream0_full,
  output logic [DATA_W-1:0]          outStream0_data,
  output logic                       outStream0_wr,
  input  logic                       outStream0_full,
  input  logic [NTAPS*COEFF_W-1:0]   coeff,
  input  logic                       cfg_mode,
  input  logic                       flush,
  output logic [31:0]                sample_count
);

  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam int PROD_W = DATA_W + COEFF_W;
  localparam int ACC_W  = PROD_W + $clog2(NTAPS);
  // Keep at least one delay element so the array is never zero-sized.
  localparam int DLY_N  = (NTAPS > 1) ? NTAPS - 1 : 1;

  // Saturation bounds expressed at accumulator width.
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'({1'b0, {(DATA_W-1){1'b1}}});
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0]        mem [FIFO_DEPTH];
  logic [AW-1:0]            wr_ptr_reg;
  logic [AW-1:0]            rd_ptr_reg;
  logic [AW:0]              count_reg;
  logic signed [DATA_W-1:0] dly_reg [DLY_N];
  logic [DATA_W-1:0]        out_data_reg;
  logic                     out_valid_reg;
  logic [31:0]              sample_count_reg;

  // ---------------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------------
  logic                     fifo_full;
  logic                     fifo_empty;
  logic                     push;
  logic                     out_wr;
  logic                     accept;
  logic signed [DATA_W-1:0] head;

  assign fifo_full  = (count_reg == (AW+1)'(FIFO_DEPTH));
  assign fifo_empty = (count_reg == '0);
  assign head       = mem[rd_ptr_reg];

  // Flush wins over everything in its cycle: no store, no pop, no strobe.
  assign push   = inStream0_wr & ~fifo_full & ~flush;
  assign out_wr = out_valid_reg & ~outStream0_full & ~flush;
  // The output register may refill in the same cycle its beat drains.
  assign accept = ~fifo_empty & (~out_valid_reg | out_wr) & ~flush;

  assign inStream0_full  = fifo_full;
  assign outStream0_wr   = out_wr;
  assign outStream0_data = out_data_reg;
  assign sample_count    = sample_count_reg;

  // ---------------------------------------------------------------------------
  // FIFO storage (no reset needed: validity is tracked by the pointers)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr_reg] <= inStream0_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Tap products: tap 0 is the sample being accepted, tap k>0 is d[k-1].
  // ---------------------------------------------------------------------------
  logic signed [PROD_W-1:0] prod [NTAPS];

  for (genvar gi = 0; gi < NTAPS; gi++) begin : g_tap
    logic signed [COEFF_W-1:0] c;
    logic signed [DATA_W-1:0]  s;

    assign c = coeff[gi*COEFF_W +: COEFF_W];

    if (gi == 0) begin : g_head
      assign s = head;
    end else begin : g_dly
      assign s = dly_reg[gi-1];
    end

    // Both operands are sign-extended to the full product width first.
    assign prod[gi] = PROD_W'(s) * PROD_W'(c);
  end

  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  shifted;
  logic [DATA_W-1:0]        fir_result;

  always_comb begin
    acc = '0;
    for (int k = 0; k < NTAPS; k++) begin
      acc = acc + ACC_W'(prod[k]);
    end
  end

  assign shifted = acc >>> SHIFT;

  always_comb begin
    if (shifted > SAT_MAX) begin
      fir_result = {1'b0, {(DATA_W-1){1'b1}}};
    end else if (shifted < SAT_MIN) begin
      fir_result = {1'b1, {(DATA_W-1){1'b0}}};
    end else begin
      fir_result = shifted[DATA_W-1:0];
    end
  end

  // ---------------------------------------------------------------------------
  // Pointers, count, delay line, output register, sample counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg       <= '0;
      rd_ptr_reg       <= '0;
      count_reg        <= '0;
      out_valid_reg    <= 1'b0;
      out_data_reg     <= '0;
      sample_count_reg <= '0;
      for (int k = 0; k < DLY_N; k++) begin
        dly_reg[k] <= '0;
      end
    end else if (flush) begin
      wr_ptr_reg       <= '0;
      rd_ptr_reg       <= '0;
      count_reg        <= '0;
      out_valid_reg    <= 1'b0;
      out_data_reg     <= '0;
      sample_count_reg <= '0;
      for (int k = 0; k < DLY_N; k++) begin
        dly_reg[k] <= '0;
      end
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (accept) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end

      case ({push, accept})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase

      if (accept) begin
        // The delay line shifts in both modes so leaving bypass is seamless.
        dly_reg[0] <= head;
        for (int k = 1; k < DLY_N; k++) begin
          dly_reg[k] <= dly_reg[k-1];
        end
        out_data_reg  <= cfg_mode ? head : fir_result;
        out_valid_reg <= 1'b1;
      end else if (out_wr) begin
        out_valid_reg <= 1'b0;
      end

      if (out_wr) begin
        sample_count_reg <= sample_count_reg + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_stream_fir_ntap.sv
// -----------------------------------------------------------------------------
// tb_stream_fir_ntap
//
// Directed bench for stream_fir_ntap. A table of single-sample records
// (coefficients, mode, input, expected output) covers impulse response,
// bypass mid-stream and saturation; hand-written sequences cover output
// scaling (second instance with SHIFT=2), backpressure with a full FIFO,
// and flush / reset while samples are queued.
// -----------------------------------------------------------------------------
module tb_stream_fir_ntap;

  localparam logic [127:0] C_IMP = {32'd4, 32'd3, 32'd2, 32'd1};
  localparam logic [127:0] C_SAT = {4{32'h7FFFFFFF}};
  localparam logic [127:0] C_SH  = {32'd0, 32'd0, 32'd0, 32'd4};

  logic         clock;
  logic         reset;
  logic [31:0]  in_data;
  logic         in_wr;
  logic         in_full;
  logic [31:0]  out_data;
  logic         out_wr;
  logic         out_full;
  logic [127:0] coeff;
  logic         cfg_mode;
  logic         flush;
  logic [31:0]  sample_count;

  logic         s2_in_full;
  logic [31:0]  s2_out_data;
  logic         s2_out_wr;
  logic         s2_out_full;
  logic [31:0]  s2_sample_count;

  int checks = 0;
  int errors = 0;

  logic [31:0] q1[$];
  logic [31:0] q2[$];

  stream_fir_ntap dut (
    .clock          (clock),
    .reset          (reset),
    .inStream0_data (in_data),
    .inStream0_wr   (in_wr),
    .inStream0_full (in_full),
    .outStream0_data(out_data),
    .outStream0_wr  (out_wr),
    .outStream0_full(out_full),
    .coeff          (coeff),
    .cfg_mode       (cfg_mode),
    .flush          (flush),
    .sample_count   (sample_count)
  );

  stream_fir_ntap #(.SHIFT(2)) dut_s2 (
    .clock          (clock),
    .reset          (reset),
    .inStream0_data (in_data),
    .inStream0_wr   (in_wr),
    .inStream0_full (s2_in_full),
    .outStream0_data(s2_out_data),
    .outStream0_wr  (s2_out_wr),
    .outStream0_full(s2_out_full),
    .coeff          (coeff),
    .cfg_mode       (cfg_mode),
    .flush          (flush),
    .sample_count   (s2_sample_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Output beats are captured mid-cycle, away from the active edge.
  always @(negedge clock) begin
    if (out_wr)    q1.push_back(out_data);
    if (s2_out_wr) q2.push_back(s2_out_data);
  end

  typedef struct {
    logic         flush_first;
    logic [127:0] cf;
    logic         mode;
    logic [31:0]  din;
    logic [31:0]  exp;
    int           cnt_exp;   // expected sample_count after this record, -1 = skip
  } vec_t;

  vec_t tbl [21];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [31:0] d);
    in_data = d;
    in_wr   = 1'b1;
    tick();
    in_wr   = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic get1(input string name, input logic [31:0] exp);
    int n = 0;
    while (q1.size() == 0 && n < 50) begin
      tick();
      n++;
    end
    if (q1.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: no output within 50 cycles, expected %h", name, exp);
    end else begin
      logic [31:0] v;
      v = q1.pop_front();
      $display("out %s: got %h expected %h", name, v, exp);
      check(name, v, exp);
    end
  endtask

  task automatic get2(input string name, input logic [31:0] exp);
    int n = 0;
    while (q2.size() == 0 && n < 50) begin
      tick();
      n++;
    end
    if (q2.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: no output within 50 cycles, expected %h", name, exp);
    end else begin
      logic [31:0] v;
      v = q2.pop_front();
      $display("out %s: got %h expected %h", name, v, exp);
      check(name, v, exp);
    end
  endtask

  initial begin
    int stored;
    int n;

    // Impulse: 1,0,0,0,0 -> 1,2,3,4,0
    tbl[0]  = '{1'b1, C_IMP, 1'b0, 32'd1, 32'd1, -1};
    tbl[1]  = '{1'b0, C_IMP, 1'b0, 32'd0, 32'd2, -1};
    tbl[2]  = '{1'b0, C_IMP, 1'b0, 32'd0, 32'd3, -1};
    tbl[3]  = '{1'b0, C_IMP, 1'b0, 32'd0, 32'd4, -1};
    tbl[4]  = '{1'b0, C_IMP, 1'b0, 32'd0, 32'd0, 5};
    // Ramp 1..8, samples 3..5 bypassed; 6..8 use delay line holding 3..5
    tbl[5]  = '{1'b1, C_IMP, 1'b0, 32'd1, 32'd1,  -1};
    tbl[6]  = '{1'b0, C_IMP, 1'b0, 32'd2, 32'd4,  -1};
    tbl[7]  = '{1'b0, C_IMP, 1'b1, 32'd3, 32'd3,  -1};
    tbl[8]  = '{1'b0, C_IMP, 1'b1, 32'd4, 32'd4,  -1};
    tbl[9]  = '{1'b0, C_IMP, 1'b1, 32'd5, 32'd5,  -1};
    tbl[10] = '{1'b0, C_IMP, 1'b0, 32'd6, 32'd40, -1};
    tbl[11] = '{1'b0, C_IMP, 1'b0, 32'd7, 32'd50, -1};
    tbl[12] = '{1'b0, C_IMP, 1'b0, 32'd8, 32'd60, 8};
    // Saturation, positive then (after a flush) negative
    tbl[13] = '{1'b1, C_SAT, 1'b0, 32'h7FFFFFFF, 32'h7FFFFFFF, -1};
    tbl[14] = '{1'b0, C_SAT, 1'b0, 32'h7FFFFFFF, 32'h7FFFFFFF, -1};
    tbl[15] = '{1'b0, C_SAT, 1'b0, 32'h7FFFFFFF, 32'h7FFFFFFF, -1};
    tbl[16] = '{1'b0, C_SAT, 1'b0, 32'h7FFFFFFF, 32'h7FFFFFFF, -1};
    tbl[17] = '{1'b1, C_SAT, 1'b0, 32'h80000000, 32'h80000000, -1};
    tbl[18] = '{1'b0, C_SAT, 1'b0, 32'h80000000, 32'h80000000, -1};
    tbl[19] = '{1'b0, C_SAT, 1'b0, 32'h80000000, 32'h80000000, -1};
    tbl[20] = '{1'b0, C_SAT, 1'b0, 32'h80000000, 32'h80000000, 4};

    reset       = 1'b0;
    in_data     = '0;
    in_wr       = 1'b0;
    out_full    = 1'b0;
    s2_out_full = 1'b0;
    coeff       = C_IMP;
    cfg_mode    = 1'b0;
    flush       = 1'b0;
    tick();
    tick();

    // Reset values
    check("rst_in_full",  32'(in_full), 32'd0);
    check("rst_out_wr",   32'(out_wr), 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_count",    sample_count, 32'd0);
    reset = 1'b1;
    tick();

    // Table-driven single-sample records
    for (int i = 0; i < 21; i++) begin
      if (tbl[i].flush_first) do_flush();
      coeff    = tbl[i].cf;
      cfg_mode = tbl[i].mode;
      send(tbl[i].din);
      get1($sformatf("vec%0d", i), tbl[i].exp);
      if (tbl[i].cnt_exp >= 0) begin
        tick();
        check($sformatf("vec%0d_count", i), sample_count, 32'(tbl[i].cnt_exp));
      end
    end

    // Output scaling on the SHIFT=2 instance: coeff 4 undoes the shift
    do_flush();
    coeff    = C_SH;
    cfg_mode = 1'b0;
    q2.delete();
    send(32'd5);
    get2("shift_pos", 32'd5);
    send(32'hFFFFFFF9);
    get2("shift_neg", 32'hFFFFFFF9);
    repeat (4) tick();
    q1.delete();

    // Backpressure: 70 writes, 65 stored, bypass so outputs equal inputs
    do_flush();
    cfg_mode = 1'b1;
    out_full = 1'b1;
    stored   = 0;
    for (int i = 0; i < 70; i++) begin
      in_data = 32'(i);
      in_wr   = 1'b1;
      if (!in_full) stored++;
      tick();
    end
    in_wr = 1'b0;
    $display("backpressure: %0d writes stored", stored);
    check("bp_stored", 32'(stored), 32'd65);
    check("bp_full", 32'(in_full), 32'd1);
    repeat (3) tick();
    check("bp_no_out", 32'(q1.size()), 32'd0);
    out_full = 1'b0;
    check("bp_full_hold", 32'(in_full), 32'd1);
    tick();
    check("bp_full_drop", 32'(in_full), 32'd0);
    n = 0;
    while (q1.size() < 65 && n < 200) begin
      tick();
      n++;
    end
    repeat (5) tick();
    check("bp_out_count", 32'(q1.size()), 32'd65);
    for (int i = 0; i < 65; i++) begin
      if (q1.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL bp_out%0d: missing, expected %h", i, 32'(i));
      end else begin
        check($sformatf("bp_out%0d", i), q1.pop_front(), 32'(i));
      end
    end
    check("bp_full_end", 32'(in_full), 32'd0);
    q1.delete();

    // Flush with 10 samples queued; downstream released in the flush cycle
    coeff    = C_IMP;
    cfg_mode = 1'b0;
    out_full = 1'b1;
    for (int i = 0; i < 10; i++) send(32'd9);
    flush    = 1'b1;
    out_full = 1'b0;
    tick();
    flush = 1'b0;
    repeat (20) tick();
    $display("flush: %0d stray outputs, sample_count %0d", q1.size(), sample_count);
    check("flush_no_out", 32'(q1.size()), 32'd0);
    check("flush_count", sample_count, 32'd0);
    check("flush_in_full", 32'(in_full), 32'd0);
    q1.delete();
    send(32'd1); get1("flush_imp0", 32'd1);
    send(32'd0); get1("flush_imp1", 32'd2);
    send(32'd0); get1("flush_imp2", 32'd3);
    send(32'd0); get1("flush_imp3", 32'd4);

    // Same with a one-cycle reset pulse
    out_full = 1'b1;
    for (int i = 0; i < 10; i++) send(32'd9);
    reset    = 1'b0;
    out_full = 1'b0;
    #1;
    check("arst_out_wr", 32'(out_wr), 32'd0);
    check("arst_count",  sample_count, 32'd0);
    check("arst_in_full", 32'(in_full), 32'd0);
    tick();
    reset = 1'b1;
    repeat (20) tick();
    $display("reset: %0d stray outputs, sample_count %0d", q1.size(), sample_count);
    check("rst_no_out", 32'(q1.size()), 32'd0);
    check("rst_count2", sample_count, 32'd0);
    q1.delete();
    send(32'd1); get1("rst_imp0", 32'd1);
    send(32'd0); get1("rst_imp1", 32'd2);
    send(32'd0); get1("rst_imp2", 32'd3);
    send(32'd0); get1("rst_imp3", 32'd4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/stream_fir_ntap.md
# stream_fir_ntap

Parametrised streaming N-tap FIR kernel for multi-dataflow networks. Supports configurable data width, coefficient width, tap count and input FIFO depth. Adds a bypass mode, a synchronous flush, fixed-point output scaling with saturation, and an output sample counter. Sits between the network input stream (wr/full push protocol) and the network output stream, with coefficients driven as dynamic parameters from the register file.

## Interface
- DATA_W, 32: sample width, signed two's complement.
- COEFF_W, 32: coefficient width, signed.
- NTAPS, 4: tap count, legal range 1..16.
- FIFO_DEPTH, 64: input FIFO entries, power of two, ≥2.
- SHIFT, 0: arithmetic right shift applied to the accumulator before saturation, 0..(COEFF_W+clog2(NTAPS)).

Ports:
- clock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- inStream0_data  in  DATA_W  input sample.
- inStream0_wr  in  1  write strobe, one sample per cycle.
- inStream0_full  out  1  FIFO full; writes while high are dropped.
- outStream0_data  out  DATA_W  result sample.
- outStream0_wr  out  1  result valid this cycle, one sample per strobe.
- outStream0_full  in  1  downstream full; no write while high.
- coeff  in  NTAPS*COEFF_W  packed coefficients; c_k = coeff[k*COEFF_W +: COEFF_W].
- cfg_mode  in  1  0 = FIR, 1 = bypass.
- flush  in  1  synchronous clear of FIFO, delay line and output register.
- sample_count  out  32  number of outStream0_wr strobes since reset or flush; wraps at 2^32.

## Operation
- Input FIFO: first-word-fall-through with count register. inStream0_full = (count == FIFO_DEPTH). A write when not full is stored. A read and a write in the same cycle leave count unchanged.
- Output register: out_data and out_valid.
  - accept = FIFO non-empty & (~out_valid | outStream0_wr).
  - On accept: pop the FIFO head x, shift it into delay line d[0..NTAPS-2], load out_data, set out_valid=1.
  - Otherwise, outStream0_wr clears out_valid.
- outStream0_wr = out_valid & ~outStream0_full. outStream0_data = out_data (held stable while out_valid).
- FIR (cfg_mode=0): acc = c_0*x + Σ_{k=1}^{NTAPS-1} c_k*d[k-1], computed at full precision.
  - Product width DATA_W+COEFF_W; accumulator width DATA_W+COEFF_W+clog2(NTAPS).
  - Result = acc >>> SHIFT, saturated to [−2^(DATA_W−1), 2^(DATA_W−1)−1].
- Bypass (cfg_mode=1): out_data = x. The delay line still shifts, so returning to FIR mode is seamless.
- cfg_mode and coeff are sampled at the accept cycle only.
- flush (highest priority after reset): count=0, delay line=0, out_valid=0, sample_count=0. A write or accept in the flush cycle is discarded. outStream0_wr is forced low in the flush cycle.
- sample_count increments on every outStream0_wr.

## Timing
- Reset values: inStream0_full=0, outStream0_wr=0, outStream0_data=0, sample_count=0, FIFO empty, delay line all 0.
- Reset assertion mid-stream discards all in-flight data immediately (asynchronous).
- Latency, with an empty FIFO and outStream0_full low:
  - write at cycle t;
  - head visible at t+1;
  - accepted at t+1;
  - outStream0_wr at t+2.
- Throughput: 1 sample per cycle sustained when outStream0_full stays low.
- With outStream0_full held high:
  - the output register holds one sample and the FIFO holds FIFO_DEPTH more;
  - inStream0_full rises on the cycle after the FIFO_DEPTH-th stored write.
- Full deasserts the cycle after the first pop from a full FIFO.
- outStream0_full is sampled combinationally. The data beat completes in the same cycle as the strobe, so there is no bubble on the back-to-back drain/accept path.

## Test plan
- Impulse, NTAPS=4, SHIFT=0, coeff=1,2,3,4, FIR mode. Input 1,0,0,0,0 → output 1,2,3,4,0. sample_count=5.
- Saturation, DATA_W=COEFF_W=32, all coeff=0x7FFFFFFF:
  - input 0x7FFFFFFF ×4 → each output 0x7FFFFFFF;
  - input 0x80000000 ×4 with the same coefficients → 0x80000000.
- SHIFT=2, coeff=4,0,0,0. Input 5,−7 → outputs 5, −7.
- Backpressure, FIFO_DEPTH=64, outStream0_full high:
  - write 70 samples 0..69; 65 are stored (1 in the output register, 64 in the FIFO) and inStream0_full=1 after the 65th;
  - release full → 65 outputs in order, then inStream0_full=0, with no duplicates or gaps.
- Bypass mid-stream:
  - ramp 1..8 with cfg_mode=1 for samples 3..5 → outputs for samples 3..5 equal the raw inputs;
  - samples 6..8 resume FIR using the delay line that contains samples 3..5.
- Flush and reset mid-stream: with 10 samples queued, pulse flush → no further outStream0_wr, sample_count=0, next impulse gives 1,2,3,4. The same check with reset low for 1 cycle gives the same result.
